data_bus_if: RTL and testbench

- Data-side bus interface between the memory-access stage and the external data bus.
- Takes the stage's per-cycle access request (chip enable, address, write enable, byte select, write data) and turns it into a multi-cycle request/acknowledge bus transaction.
- Raises a pipeline stall request until the slave acknowledges, and returns load data to the stage.
- Buffers load data while the pipeline is still frozen by other stall sources, and aborts cleanly on flush.

---
 rtl/data_bus_if.sv | 114 +++++++++++
 tb/tb_data_bus_if.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_if.sv
// Data-side bus interface: turns the memory-access stage's per-cycle access into a
// request/acknowledge bus transaction, stalling the pipeline until the slave answers.
module data_bus_if #(
  parameter int unsigned STALL_IDX   = 3,
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_addr_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_data_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_data_o,
  input  logic [31:0] bus_data_i,
  input  logic        bus_ack_i,
  output logic        bus_err_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [7:0] TimeoutLast = 8'(BUS_TIMEOUT - 1);

  logic [1:0]  r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_rd_buf;

  logic        w_frozen;
  logic        w_busy;
  logic        w_timeout;
  logic        w_done;
  logic [31:0] w_ack_data;

  assign w_frozen  = stall[STALL_IDX];
  assign w_busy    = (r_state == S_BUSY) && !flush;
  // Timeout only fires when no ack arrives in the same cycle; a real ack always wins.
  assign w_timeout = w_busy && !bus_ack_i && (r_cnt == TimeoutLast);
  assign w_done    = w_busy && (bus_ack_i || w_timeout);
  assign w_ack_data = (w_busy && bus_ack_i && !bus_we_o) ? bus_data_i : 32'h0;

  always_comb begin
    stallreq   = 1'b0;
    cpu_data_o = 32'h0;
    bus_err_o  = 1'b0;
    if (!rst && !flush) begin
      case (r_state)
        S_IDLE: stallreq = cpu_ce_i;
        S_BUSY: begin
          stallreq   = !w_done;
          cpu_data_o = w_ack_data;
          bus_err_o  = w_timeout;
        end
        S_HOLD: cpu_data_o = r_rd_buf;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'h0;
      r_rd_buf   <= 32'h0;
      bus_req_o  <= 1'b0;
      bus_we_o   <= 1'b0;
      bus_addr_o <= 32'h0;
      bus_sel_o  <= 4'h0;
      bus_data_o <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cpu_ce_i) begin
            r_state    <= S_BUSY;
            r_cnt      <= 8'h0;
            bus_req_o  <= 1'b1;
            bus_we_o   <= cpu_we_i;
            bus_addr_o <= cpu_addr_i;
            bus_sel_o  <= cpu_sel_i;
            bus_data_o <= cpu_data_i;
          end
        end
        S_BUSY: begin
          if (w_done) begin
            r_state    <= w_frozen ? S_HOLD : S_IDLE;
            r_cnt      <= 8'h0;
            r_rd_buf   <= w_ack_data;
            bus_req_o  <= 1'b0;
            bus_we_o   <= 1'b0;
            bus_addr_o <= 32'h0;
            bus_sel_o  <= 4'h0;
            bus_data_o <= 32'h0;
          end else begin
            r_cnt <= r_cnt + 8'h1;
          end
        end
        S_HOLD: begin
          if (!w_frozen) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_if.sv
// Bench for data_bus_if: transaction-level model checked every cycle plus directed
// literal expectations for each scenario.
module tb_data_bus_if;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        cpu_ce_i;
  logic [31:0] cpu_addr_i;
  logic        cpu_we_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_i;
  logic [31:0] cpu_data_o;
  logic        stallreq;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_data_o;
  logic [31:0] bus_data_i;
  logic        bus_ack_i;
  logic        bus_err_o;

  int checks = 0;
  int errors = 0;

  data_bus_if #(.STALL_IDX(3), .BUS_TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .flush     (flush),
    .cpu_ce_i  (cpu_ce_i),
    .cpu_addr_i(cpu_addr_i),
    .cpu_we_i  (cpu_we_i),
    .cpu_sel_i (cpu_sel_i),
    .cpu_data_i(cpu_data_i),
    .cpu_data_o(cpu_data_o),
    .stallreq  (stallreq),
    .bus_req_o (bus_req_o),
    .bus_we_o  (bus_we_o),
    .bus_addr_o(bus_addr_o),
    .bus_sel_o (bus_sel_o),
    .bus_data_o(bus_data_o),
    .bus_data_i(bus_data_i),
    .bus_ack_i (bus_ack_i),
    .bus_err_o (bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Transaction-level model: an outstanding access, how long it has waited, and the
  // load result parked while the pipeline stays frozen.
  bit          m_known = 0;
  bit          m_pending = 0;
  bit          m_parked = 0;
  int          m_waited = 0;
  logic        m_we;
  logic [31:0] m_addr, m_wdata, m_buf = 0;
  logic [3:0]  m_sel;

  always @(negedge clk) begin
    logic        finish_now, timed_out;
    logic        e_stallreq, e_err;
    logic [31:0] e_data;
    finish_now = m_pending && !flush && (bus_ack_i || m_waited == int'(TO) - 1);
    timed_out  = m_pending && !flush && !bus_ack_i && m_waited == int'(TO) - 1;
    e_stallreq = 1'b0;
    e_err      = 1'b0;
    e_data     = 32'h0;
    if (!rst && !flush) begin
      if (m_pending) begin
        e_stallreq = !finish_now;
        e_err      = timed_out;
        if (bus_ack_i && !m_we) e_data = bus_data_i;
      end else if (m_parked) begin
        e_data = m_buf;
      end else begin
        e_stallreq = cpu_ce_i;
      end
    end
    if (m_known) begin
      check("m_req",  {31'h0, bus_req_o}, {31'h0, m_pending});
      check("m_we",   {31'h0, bus_we_o},  m_pending ? {31'h0, m_we} : 32'h0);
      check("m_addr", bus_addr_o,         m_pending ? m_addr : 32'h0);
      check("m_sel",  {28'h0, bus_sel_o}, m_pending ? {28'h0, m_sel} : 32'h0);
      check("m_wdat", bus_data_o,         m_pending ? m_wdata : 32'h0);
      check("m_stallreq", {31'h0, stallreq}, {31'h0, e_stallreq});
      check("m_err",  {31'h0, bus_err_o}, {31'h0, e_err});
      check("m_rdat", cpu_data_o, e_data);
    end
    if (rst || flush) begin
      if (rst) m_known = 1;
      m_pending = 0;
      m_parked  = 0;
      m_buf     = 0;
    end else if (m_pending) begin
      if (finish_now) begin
        m_pending = 0;
        m_buf     = (bus_ack_i && !m_we) ? bus_data_i : 32'h0;
        m_parked  = stall[3];
      end else begin
        m_waited++;
      end
    end else if (m_parked) begin
      if (!stall[3]) m_parked = 0;
    end else if (cpu_ce_i) begin
      m_pending = 1;
      m_waited  = 0;
      m_we      = cpu_we_i;
      m_addr    = cpu_addr_i;
      m_sel     = cpu_sel_i;
      m_wdata   = cpu_data_i;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic request(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                         input logic [31:0] wdata);
    cpu_ce_i   = 1'b1;
    cpu_we_i   = we;
    cpu_addr_i = addr;
    cpu_sel_i  = sel;
    cpu_data_i = wdata;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; stall = 6'h0; flush = 1'b0; cpu_ce_i = 1'b0; cpu_addr_i = 32'h0;
    cpu_we_i = 1'b0; cpu_sel_i = 4'h0; cpu_data_i = 32'h0; bus_data_i = 32'h0;
    bus_ack_i = 1'b0;
    step(); step();
    rst = 1'b0;
    settle();
    check("rst_req", {31'h0, bus_req_o}, 32'h0);
    check("rst_stallreq", {31'h0, stallreq}, 32'h0);
    check("rst_rdat", cpu_data_o, 32'h0);
    check("rst_err", {31'h0, bus_err_o}, 32'h0);

    // Load, ack three cycles after the request rises.
    step();
    request(1'b0, 32'h0000_0104, 4'hF, 32'h0);
    settle();
    check("ld_stall_idle", {31'h0, stallreq}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("ld_req", {31'h0, bus_req_o}, 32'h1);
      check("ld_addr", bus_addr_o, 32'h0000_0104);
      check("ld_stall_busy", {31'h0, stallreq}, 32'h1);
    end
    step();
    bus_ack_i = 1'b1; bus_data_i = 32'hDEAD_BEEF;
    settle();
    check("ld_stall_ack", {31'h0, stallreq}, 32'h0);
    check("ld_rdat_ack", cpu_data_o, 32'hDEAD_BEEF);
    check("ld_err_ack", {31'h0, bus_err_o}, 32'h0);
    step();
    bus_ack_i = 1'b0; bus_data_i = 32'h0; cpu_ce_i = 1'b0;
    settle();
    check("ld_req_after", {31'h0, bus_req_o}, 32'h0);
    check("ld_rdat_after", cpu_data_o, 32'h0);

    // Store, ack on the second busy cycle: stall request high for two cycles.
    step();
    request(1'b1, 32'h0000_0020, 4'b0011, 32'h0000_ABCD);
    settle();
    check("st_stall_idle", {31'h0, stallreq}, 32'h1);
    step();
    check("st_we", {31'h0, bus_we_o}, 32'h1);
    check("st_sel", {28'h0, bus_sel_o}, 32'h3);
    check("st_wdat", bus_data_o, 32'h0000_ABCD);
    check("st_stall_busy", {31'h0, stallreq}, 32'h1);
    step();
    bus_ack_i = 1'b1; bus_data_i = 32'hFFFF_FFFF;
    settle();
    check("st_stall_ack", {31'h0, stallreq}, 32'h0);
    check("st_rdat_ack", cpu_data_o, 32'h0);
    step();
    bus_ack_i = 1'b0; bus_data_i = 32'h0; cpu_ce_i = 1'b0;
    settle();
    check("st_req_after", {31'h0, bus_req_o}, 32'h0);

    // Load completes while the stage is frozen: result held until release.
    step();
    request(1'b0, 32'h0000_0040, 4'hF, 32'h0);
    step();
    step();
    bus_ack_i = 1'b1; bus_data_i = 32'h1234_5678; stall = 6'b001000;
    settle();
    check("hd_rdat_ack", cpu_data_o, 32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      step();
      bus_ack_i = 1'b1; bus_data_i = 32'hCAFE_0000 + i;
      if (i == 2) stall = 6'h0;
      settle();
      check("hd_rdat", cpu_data_o, 32'h1234_5678);
      check("hd_stallreq", {31'h0, stallreq}, 32'h0);
      check("hd_req", {31'h0, bus_req_o}, 32'h0);
    end
    step();
    bus_ack_i = 1'b0; bus_data_i = 32'h0; cpu_ce_i = 1'b0;
    settle();
    check("hd_rdat_idle", cpu_data_o, 32'h0);

    // Flush in the same cycle as an ack.
    step();
    request(1'b0, 32'h0000_0080, 4'hF, 32'h0);
    step(); step();
    step();
    flush = 1'b1; bus_ack_i = 1'b1; bus_data_i = 32'h55AA_55AA;
    settle();
    check("fl_stallreq", {31'h0, stallreq}, 32'h0);
    check("fl_rdat", cpu_data_o, 32'h0);
    step();
    flush = 1'b0; bus_ack_i = 1'b0; bus_data_i = 32'h0; cpu_ce_i = 1'b0;
    settle();
    check("fl_req_after", {31'h0, bus_req_o}, 32'h0);
    check("fl_rdat_after", cpu_data_o, 32'h0);
    // Stray ack in idle, then flush with a pending request in idle.
    bus_ack_i = 1'b1; bus_data_i = 32'h7777_7777;
    settle();
    check("idle_ack_rdat", cpu_data_o, 32'h0);
    step();
    bus_ack_i = 1'b0;
    request(1'b0, 32'h0000_0090, 4'hF, 32'h0);
    flush = 1'b1;
    settle();
    check("idle_fl_stallreq", {31'h0, stallreq}, 32'h0);
    step();
    flush = 1'b0; cpu_ce_i = 1'b0;
    settle();
    check("idle_fl_req", {31'h0, bus_req_o}, 32'h0);

    // Slave never answers: timeout on the fourth busy cycle.
    step();
    request(1'b0, 32'h0000_0100, 4'hF, 32'h0);
    for (int i = 0; i < int'(TO); i++) begin
      step();
      bus_data_i = 32'hABAB_ABAB;
      settle();
      check("to_err", {31'h0, bus_err_o}, (i == int'(TO) - 1) ? 32'h1 : 32'h0);
      check("to_stallreq", {31'h0, stallreq}, (i == int'(TO) - 1) ? 32'h0 : 32'h1);
      check("to_rdat", cpu_data_o, 32'h0);
    end
    step();
    cpu_ce_i = 1'b0;
    settle();
    check("to_req_after", {31'h0, bus_req_o}, 32'h0);
    check("to_err_after", {31'h0, bus_err_o}, 32'h0);

    // Back-to-back: request held high right after an ack costs one idle cycle.
    step();
    request(1'b1, 32'h0000_0200, 4'h1, 32'h0000_00EE);
    step();
    bus_ack_i = 1'b1;
    step();
    bus_ack_i = 1'b0;
    request(1'b0, 32'h0000_0204, 4'hF, 32'h0);
    settle();
    check("b2b_idle_req", {31'h0, bus_req_o}, 32'h0);
    step();
    check("b2b_new_addr", bus_addr_o, 32'h0000_0204);

    // Reset in the middle of a transaction; a late ack changes nothing.
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; cpu_ce_i = 1'b0; bus_ack_i = 1'b1; bus_data_i = 32'h9999_9999;
    settle();
    check("rs_req", {31'h0, bus_req_o}, 32'h0);
    check("rs_addr", bus_addr_o, 32'h0);
    check("rs_stallreq", {31'h0, stallreq}, 32'h0);
    check("rs_rdat", cpu_data_o, 32'h0);
    step();
    bus_ack_i = 1'b0;
    settle();
    check("rs_req_late", {31'h0, bus_req_o}, 32'h0);
    check("rs_rdat_late", cpu_data_o, 32'h0);
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
